// File: rtl/ps2_pkg.sv
// Shared PS/2 key tracker definitions: prefix/ignored byte codes, frame bit
// positions, prefix FSM encoding and the key event payload.
package ps2_pkg;

  localparam int unsigned KEY_W   = 9;
  localparam int unsigned KEY_NUM = 1 << KEY_W;
  localparam int unsigned BIT_W   = 4;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [7:0] IGN_00 = 8'h00;
  localparam logic [7:0] IGN_AA = 8'hAA;
  localparam logic [7:0] IGN_EE = 8'hEE;
  localparam logic [7:0] IGN_FA = 8'hFA;
  localparam logic [7:0] IGN_FE = 8'hFE;
  localparam logic [7:0] IGN_FF = 8'hFF;

  // Frame bit index: 0 start, 1..8 data, 9 parity, 10 stop
  localparam logic [BIT_W-1:0] BIT_DATA_LAST = 4'd8;
  localparam logic [BIT_W-1:0] BIT_PARITY    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  typedef struct packed {
    logic             make;
    logic [KEY_W-1:0] code;
  } key_event_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_00) || (b == IGN_AA) || (b == IGN_EE) ||
           (b == IGN_FA) || (b == IGN_FE) || (b == IGN_FF);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 serial frame receiver: synchronizers, clock glitch filter, 11-bit framing
// with timeout. Define PS2_PARITY_CHECK_EN to drop frames failing odd parity.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid
);

  localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_clk, flt_clk_d;
  logic             fall_c;
  logic [BIT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       shreg;
  logic             start_bit;
  logic             frame_ok_c;
`ifdef PS2_PARITY_CHECK_EN
  logic             parity_bit;
`endif

  // Two-flop synchronizers, idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Level flips only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt   <= '0;
      flt_clk   <= 1'b1;
      flt_clk_d <= 1'b1;
    end else begin
      flt_clk_d <= flt_clk;
      if (clk_s2 == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        flt_clk <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  assign fall_c = flt_clk_d & ~flt_clk;

  always_comb begin
    frame_ok_c = ~start_bit & dat_s2;
`ifdef PS2_PARITY_CHECK_EN
    frame_ok_c = frame_ok_c & (^{shreg, parity_bit});
`endif
  end

  // All 11 bits are always consumed so a bad start bit cannot misalign the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      to_cnt     <= '0;
      shreg      <= '0;
      start_bit  <= 1'b0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
      if (fall_c) begin
        to_cnt <= '0;
        if (bit_cnt == '0) begin
          start_bit <= dat_s2;
          bit_cnt   <= BIT_W'(1);
        end else if (bit_cnt <= BIT_DATA_LAST) begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + BIT_W'(1);
        end else if (bit_cnt == BIT_PARITY) begin
`ifdef PS2_PARITY_CHECK_EN
          parity_bit <= dat_s2;
`endif
          bit_cnt <= bit_cnt + BIT_W'(1);
        end else begin
          bit_cnt <= '0;
          if (frame_ok_c) begin
            data_byte  <= shreg;
            byte_valid <= 1'b1;
          end
        end
      end else if (bit_cnt != '0) begin
        if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          bit_cnt <= '0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key state tracker: decodes E0/F0 prefixes into make/break events
// and maintains a held-key bitmap. Parity checking via PS2_PARITY_CHECK_EN.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  output logic [KEY_NUM-1:0] key_down,
  output logic [KEY_W-1:0]   last_change,
  output logic               been_ready
);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  prefix_state_t state, state_nxt;
  key_event_t    ev_c;
  logic          ev_valid_c;

  ps2_frame_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (PS2_CLK),
    .ps2_data  (PS2_DATA),
    .data_byte (rx_byte),
    .byte_valid(byte_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Prefix tracking and event decode
  always_comb begin
    state_nxt  = state;
    ev_valid_c = 1'b0;
    ev_c       = '0;
    if (byte_valid) begin
      if (rx_byte == PREFIX_EXT) begin
        state_nxt = ST_EXT;
      end else if (rx_byte == PREFIX_BRK) begin
        case (state)
          ST_IDLE: state_nxt = ST_BRK;
          ST_EXT:  state_nxt = ST_EXT_BRK;
          default: state_nxt = state;
        endcase
      end else if ((state == ST_IDLE) && is_ignored(rx_byte)) begin
        state_nxt = ST_IDLE;
      end else begin
        ev_valid_c = 1'b1;
        ev_c.make  = (state == ST_IDLE) || (state == ST_EXT);
        ev_c.code  = {(state == ST_EXT) || (state == ST_EXT_BRK), rx_byte};
        state_nxt  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_down    <= '0;
      last_change <= '0;
      been_ready  <= 1'b0;
    end else begin
      been_ready <= ev_valid_c;
      if (ev_valid_c) begin
        key_down[ev_c.code] <= ev_c.make;
        last_change         <= ev_c.code;
      end
    end
  end

endmodule
